// File: rtl/score_display_mux.sv
// -----------------------------------------------------------------------------
// score_display_mux
//
// Purpose:
//   Latches four BCD score digits from the binary-to-BCD converter and scans
//   them onto a 4-digit common-anode seven-segment display.
//   - Each digit slot begins with a guard window where every anode is off,
//     so the previous digit's segments never ghost onto the next anode.
//   - Leading zeros can be blanked.
//   - Codes above 9 are shown as a dash (segment g only).
//
// Parameters:
//   REFRESH_BITS : scan counter width; one slot = 2^(REFRESH_BITS-2) clk cycles
//   GUARD_CYCLES : dark cycles at the start of every slot (0 .. slot length-1)
//   LZB_DEFAULT  : reset value of the leading-zero-blank register
//   BLINK_BITS   : blink counter width (only with SCORE_BLINK_EN)
//
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   bcd_valid         : one-cycle strobe, bcd3..bcd0 hold a finished conversion
//   bcd3..bcd0        : thousands .. ones digit
//   lzb_en            : leading-zero-blank enable, registered every cycle
//   blink             : (SCORE_BLINK_EN only) flash the whole display
//   an                : anode enables, active-low, an[0] = ones digit
//   seg               : segments {g,f,e,d,c,b,a}, active-low
//   dp                : decimal point, active-low, permanently off
//   busy_scan         : 1 while a digit slot is lit (outside the guard window)
//
// Optional feature macro: SCORE_BLINK_EN (adds blink input and blink counter).
// -----------------------------------------------------------------------------
module score_display_mux #(
    parameter int REFRESH_BITS = 18,
    parameter int GUARD_CYCLES = 64,
    parameter bit LZB_DEFAULT  = 1'b1
`ifdef SCORE_BLINK_EN
    ,
    parameter int BLINK_BITS   = 25
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bcd_valid,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       lzb_en,
`ifdef SCORE_BLINK_EN
    input  logic       blink,
`endif
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy_scan
);

    // The slot FSM plays the role of the two top bits of the scan counter,
    // so only the low (in-slot) bits are kept as a counter.
    localparam int               LOW_W   = REFRESH_BITS - 2;
    localparam logic [LOW_W-1:0] LOW_MAX = {LOW_W{1'b1}};
    localparam logic [LOW_W-1:0] GUARD_L = LOW_W'(GUARD_CYCLES);

    typedef enum logic [1:0] {S_D0, S_D1, S_D2, S_D3} slot_e;

    slot_e            state_q, state_d;
    logic [LOW_W-1:0] cnt_q;
    logic [3:0]       dig_q [4];
    logic             lzb_q;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             busy_q, busy_d;

    logic             guard;
    logic [3:0]       cur_digit;
    logic             cur_blank;
    logic             blank3, blank2, blank1;

`ifdef SCORE_BLINK_EN
    logic [BLINK_BITS-1:0] blink_cnt_q;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;  // dash for invalid codes
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_D0;
            cnt_q   <= '0;
            lzb_q   <= LZB_DEFAULT;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            busy_q  <= 1'b0;
            for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + LOW_W'(1);
            lzb_q   <= lzb_en;
            an_q    <= an_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
            // All four digits copied together so a display frame never mixes
            // two conversions.
            if (bcd_valid) begin
                dig_q[3] <= bcd3;
                dig_q[2] <= bcd2;
                dig_q[1] <= bcd1;
                dig_q[0] <= bcd0;
            end
        end
    end

`ifdef SCORE_BLINK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
        end else if (blink) begin
            blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
        end
    end
`endif

    // ------------------------------------------------------ next-state comb
    always_comb begin
        state_d = state_q;
        if (cnt_q == LOW_MAX) begin
            case (state_q)
                S_D0:    state_d = S_D1;
                S_D1:    state_d = S_D2;
                S_D2:    state_d = S_D3;
                default: state_d = S_D0;
            endcase
        end
    end

    // ---------------------------------------------------------- output comb
    // A zero digit is blanked only when every digit above it is also blank.
    // Dash codes are non-zero, so they stop the blanking chain.
    assign blank3 = lzb_q  && (dig_q[3] == 4'd0);
    assign blank2 = blank3 && (dig_q[2] == 4'd0);
    assign blank1 = blank2 && (dig_q[1] == 4'd0);
    assign guard  = (cnt_q < GUARD_L);

    always_comb begin
        cur_digit = dig_q[0];
        cur_blank = 1'b0;
        an_d      = 4'b1111;
        seg_d     = 7'h7F;
        busy_d    = 1'b0;
        case (state_q)
            S_D0: begin cur_digit = dig_q[0]; cur_blank = 1'b0;   end
            S_D1: begin cur_digit = dig_q[1]; cur_blank = blank1; end
            S_D2: begin cur_digit = dig_q[2]; cur_blank = blank2; end
            default: begin cur_digit = dig_q[3]; cur_blank = blank3; end
        endcase
        if (!guard) begin
            an_d   = ~(4'b0001 << state_q);
            seg_d  = cur_blank ? 7'h7F : decode(cur_digit);
            busy_d = 1'b1;
        end
`ifdef SCORE_BLINK_EN
        if (blink && blink_cnt_q[BLINK_BITS-1]) begin
            an_d   = 4'b1111;
            busy_d = 1'b0;
        end
`endif
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign busy_scan = busy_q;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_score_display_mux.sv
// -----------------------------------------------------------------------------
// tb_score_display_mux
//
// Drives score_display_mux with a short scan (REFRESH_BITS=4, GUARD_CYCLES=1,
// four cycles per slot) and compares every registered output against a
// reference computed from elapsed cycles and the loaded digits.
// -----------------------------------------------------------------------------
module tb_score_display_mux;

    localparam int RB   = 4;
    localparam int GC   = 1;
    localparam int SLOT = 1 << (RB - 2);
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       bcd_valid = 1'b0;
    logic [3:0] bcd3      = 4'd0;
    logic [3:0] bcd2      = 4'd0;
    logic [3:0] bcd1      = 4'd0;
    logic [3:0] bcd0      = 4'd0;
    logic       lzb_en    = 1'b1;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy_scan;

    int errors = 0;
    int checks = 0;

    // reference state: cycles counted since reset release, loaded digits, lzb
    int         m_cnt;
    logic [3:0] m_dig [4];
    logic       m_lzb;

    score_display_mux #(
        .REFRESH_BITS (RB),
        .GUARD_CYCLES (GC),
        .LZB_DEFAULT  (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bcd_valid (bcd_valid),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .lzb_en    (lzb_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .busy_scan (busy_scan)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_lzb = 1'b1;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    endtask

    // Expected outputs for the display position reached after m_cnt cycles.
    function automatic void model_out(output logic [3:0] e_an, output logic [6:0] e_seg,
                                      output logic e_busy);
        int slot;
        int pos;
        int lead;
        slot = (m_cnt / SLOT) % 4;
        pos  = m_cnt % SLOT;
        lead = -1;  // index of most significant non-zero digit
        for (int i = 0; i < 4; i++) if (m_dig[i] != 4'd0) lead = i;
        e_an   = 4'b1111;
        e_seg  = 7'h7F;
        e_busy = 1'b0;
        if (pos >= GC) begin
            e_an[slot] = 1'b0;
            e_busy     = 1'b1;
            if (m_lzb && slot != 0 && slot > lead) e_seg = 7'h7F;
            else e_seg = SEG_TBL[m_dig[slot]];
        end
    endfunction

    // One clock: outputs after this edge reflect the state before it.
    task automatic tick(input string tag);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_busy;
        @(posedge clk);
        model_out(e_an, e_seg, e_busy);
        m_cnt++;
        if (bcd_valid) begin
            m_dig[3] = bcd3;
            m_dig[2] = bcd2;
            m_dig[1] = bcd1;
            m_dig[0] = bcd0;
        end
        m_lzb = lzb_en;
        #1;
        chk({tag, ".an"},   32'(an),        32'(e_an));
        chk({tag, ".seg"},  32'(seg),       32'(e_seg));
        chk({tag, ".busy"}, 32'(busy_scan), 32'(e_busy));
        chk({tag, ".dp"},   32'(dp),        32'd1);
    endtask

    task automatic load(input logic [3:0] d3, input logic [3:0] d2,
                        input logic [3:0] d1, input logic [3:0] d0, input string tag);
        bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
        bcd_valid = 1'b1;
        tick(tag);
        bcd_valid = 1'b0;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        model_reset();

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst.an",   32'(an),        32'hF);
        chk("rst.seg",  32'(seg),       32'h7F);
        chk("rst.busy", 32'(busy_scan), 32'd0);
        chk("rst.dp",   32'(dp),        32'd1);
        reset_n = 1'b1;

        // idle scan, zero digits blanked except ones
        run(20, "idle");

        load(4'd1, 4'd2, 4'd3, 4'd4, "ld1234");
        run(16, "s1234");

        lzb_en = 1'b1;
        load(4'd0, 4'd0, 4'd5, 4'd0, "ld0050");
        run(16, "s0050_lzb");
        lzb_en = 1'b0;
        run(17, "s0050_nolzb");

        lzb_en = 1'b1;
        load(4'd0, 4'hC, 4'd0, 4'd7, "ld0C07");
        run(16, "s0C07");

        // back-to-back strobes: the second one wins
        bcd_valid = 1'b1;
        bcd3 = 4'd9; bcd2 = 4'd8; bcd1 = 4'd7; bcd0 = 4'd6;
        tick("b2b_a");
        bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd3;
        tick("b2b_b");
        bcd_valid = 1'b0;
        run(16, "s_b2b");

        // randomized strobes, digits and lzb
        for (int i = 0; i < 240; i++) begin
            bcd_valid = ($urandom_range(0, 5) == 0);
            bcd3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bcd2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bcd1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bcd0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
            tick("rand");
        end
        bcd_valid = 1'b0;

        // mid-slot asynchronous reset while an=1011
        for (int i = 0; i < 32 && (((m_cnt - 1) % 16) != 9); i++) tick("seek");
        chk("pre_rst.an", 32'(an), 32'hB);
        reset_n = 1'b0;
        #1;
        chk("arst.an",   32'(an),        32'hF);
        chk("arst.seg",  32'(seg),       32'h7F);
        chk("arst.busy", 32'(busy_scan), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold.an",  32'(an),  32'hF);
        chk("arst_hold.seg", 32'(seg), 32'h7F);
        lzb_en  = 1'b1;
        reset_n = 1'b1;
        model_reset();
        run(24, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
